// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// with valid bit, stall/flush handling and a RUN/HALT state for the HALT opcode.
module if_fetch_unit #(
    parameter int unsigned               ADDR_W      = 16,
    parameter int unsigned               INSTR_W     = 16,
    parameter int unsigned               PC_INC      = 2,
    parameter logic [ADDR_W-1:0]         RESET_PC    = '0,
    parameter logic [INSTR_W-1:0]        NOP_INSTR   = '0,
    parameter logic [3:0]                HALT_OPCODE = 4'hF,
    parameter int unsigned               CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [ADDR_W-1:0]   ifid_pc_next,
    output logic                ifid_valid,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    typedef enum logic {StRun, StHalt} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    pc_next_q, pc_next_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [ADDR_W-1:0]    pc_plus;
    logic                 is_halt;

    assign pc_plus = pc_q + ADDR_W'(PC_INC);
    assign is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        count_d   = count_q;
        if (redirect) begin
            // Flush wins over stall; ifid_pc_next is deliberately left as-is.
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (stall) begin
            // Hold everything; a HALT word seen now is re-evaluated after release.
        end else if (state_q == StHalt) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d   = imem_rdata;
            pc_next_d = pc_plus;
            valid_d   = 1'b1;
            count_d   = count_q + CNT_W'(1);
            if (is_halt) begin
                state_d = StHalt;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc_next = pc_next_q;
    assign ifid_valid   = valid_q;
    assign halted       = (state_q == StHalt);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan scenarios with literal
// expectations plus randomized stall/redirect traffic against a behavioural model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_next;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    // Behavioural model of the fetch stage
    logic [15:0] m_pc, m_instr, m_pcn, m_cnt;
    logic        m_valid, m_halted;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_pc_next(ifid_pc_next),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        logic [15:0] w;
        if (rst) begin
            m_pc = 16'h0; m_instr = 16'h0; m_pcn = 16'h0; m_cnt = 16'h0;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc; m_instr = 16'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_halted) begin
            m_instr = 16'h0; m_valid = 1'b0;
        end else begin
            w = mem[m_pc];
            m_instr = w;
            m_pcn = m_pc + 16'd2;
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("ifid_instr", 32'(ifid_instr), 32'(m_instr));
        check("ifid_pc_next", 32'(ifid_pc_next), 32'(m_pcn));
        check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, 32'(imem_addr), 32'h0);
        check({tag, "_instr"}, 32'(ifid_instr), 32'h0);
        check({tag, "_pcn"}, 32'(ifid_pc_next), 32'h0);
        check({tag, "_valid"}, 32'(ifid_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_count"}, 32'(fetch_count), 32'h0);
    endtask

    initial begin
        logic [15:0] exp_addr [3];
        logic [15:0] exp_instr [3];
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111; mem[2] = 16'h2222; mem[4] = 16'h3333; mem[6] = 16'hF000;
        mem[16'h40] = 16'h4444; mem[16'hFFFE] = 16'h1234;
        exp_addr  = '{16'h2, 16'h4, 16'h6};
        exp_instr = '{16'h1111, 16'h2222, 16'h3333};

        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        rst = 1'b1;
        #12;
        check_reset_values("reset");
        rst = 1'b0;

        // Free run: two edges, then stall at pc=4, then the third fetch.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("run_addr", 32'(imem_addr), 32'(exp_addr[i]));
            check("run_instr", 32'(ifid_instr), 32'(exp_instr[i]));
            check("run_pcn", 32'(ifid_pc_next), 32'(exp_addr[i]));
            check("run_valid", 32'(ifid_valid), 32'h1);
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_addr", 32'(imem_addr), 32'h4);
            check("stall_instr", 32'(ifid_instr), 32'h2222);
            check("stall_count", 32'(fetch_count), 32'h2);
        end
        stall = 1'b0;
        tick();
        check("rel_instr", 32'(ifid_instr), 32'h3333);
        check("rel_pcn", 32'(ifid_pc_next), 32'h6);
        check("rel_count", 32'(fetch_count), 32'h3);

        // HALT word at address 6.
        tick();
        check("halt_instr", 32'(ifid_instr), 32'hF000);
        check("halt_valid", 32'(ifid_valid), 32'h1);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_addr", 32'(imem_addr), 32'h6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_valid", 32'(ifid_valid), 32'h0);
            check("halted_count", 32'(fetch_count), 32'h4);
        end

        // Redirect together with stall leaves HALT and flushes.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0040;
        tick();
        check("redir_addr", 32'(imem_addr), 32'h40);
        check("redir_valid", 32'(ifid_valid), 32'h0);
        check("redir_instr", 32'(ifid_instr), 32'h0);
        check("redir_halted", 32'(halted), 32'h0);
        redirect = 1'b0; stall = 1'b0;
        tick();
        check("post_redir_instr", 32'(ifid_instr), 32'h4444);
        check("post_redir_valid", 32'(ifid_valid), 32'h1);

        // PC wrap-around.
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_instr", 32'(ifid_instr), 32'h1234);
        check("wrap_pcn", 32'(ifid_pc_next), 32'h0);
        check("wrap_addr", 32'(imem_addr), 32'h0);

        // Randomized stall/redirect traffic.
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 20);
            redirect = ($urandom_range(0, 99) < 8);
            redirect_pc = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 63));
            tick();
        end
        stall = 1'b0; redirect = 1'b0;

        // Async reset mid-cycle while halted with fetch_count=5.
        mem[0] = 16'h0101; mem[2] = 16'h0202; mem[4] = 16'h0303; mem[6] = 16'h0404;
        mem[8] = 16'hF123;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_halted", 32'(halted), 32'h1);
        check("pre_rst_count", 32'(fetch_count), 32'h5);
        check("pre_rst_addr", 32'(imem_addr), 32'h8);
        #3 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        check_reset_values("rst_held");
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("after_rst_count", 32'(fetch_count), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
